tx_serial: RTL and testbench

TX_SERIAL -- requirements
Module: tx_serial

---
 rtl/tx_serial.sv | 153 +++++++++++++++
 tb/tb_tx_serial.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tx_serial.sv
// tx_serial: asynchronous-serial transmitter with a parity bit.
//
// Frame on saida_serial: start bit (0), N_BITS data bits LSB first, parity bit,
// stop bit (1). Each bit lasts CLOCK_HZ / BAUD_RATE clock cycles.
//
// Parameters:
//   BAUD_RATE - serial bit rate in bit/s
//   CLOCK_HZ  - clock frequency in Hz
//   N_BITS    - data bits per frame
//   PARITY    - 1 = odd parity, 0 = even parity
//
// Ports:
//   clock        - single clock, all state updates on its rising edge
//   reset        - synchronous, active-low reset
//   partida      - start request, level-sampled while idle
//   dados        - word to send, latched when a start request is accepted
//   saida_serial - registered serial line, idle high
//   ocupado      - high from the first start-bit cycle to the last stop-bit cycle
//   pronto       - one-cycle pulse marking frame completion
module tx_serial #(
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLOCK_HZ  = 50_000_000,
  parameter int unsigned N_BITS    = 8,
  parameter int unsigned PARITY    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              partida,
  input  logic [N_BITS-1:0] dados,
  output logic              saida_serial,
  output logic              ocupado,
  output logic              pronto
);

  localparam int unsigned CLK_P_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned TICK_W    = (CLK_P_BIT > 1) ? $clog2(CLK_P_BIT) : 1;
  localparam int unsigned BIT_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_P_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParityBit,
    StStop,
    StDone
  } state_e;

  state_e              state_q;
  logic [TICK_W-1:0]   tick_q;
  logic [BIT_W-1:0]    bit_q;
  logic [N_BITS-1:0]   shift_q;
  logic                parity_q;
  logic                line_q;
  logic                busy_q;
  logic                done_q;

  logic tick_end;
  logic accept;
  logic parity_in;

  assign tick_end  = (tick_q == TICK_LAST);
  assign parity_in = (PARITY != 0) ? ~^dados : ^dados;

  // DONE also accepts a held request so back-to-back frames are separated by
  // only the single high DONE cycle.
  assign accept = partida && ((state_q == StIdle) || (state_q == StDone));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q  <= StStart;
        shift_q  <= dados;
        parity_q <= parity_in;
        tick_q   <= '0;
        bit_q    <= '0;
        line_q   <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        // Tick counter runs only while a bit is on the line.
        if ((state_q == StStart) || (state_q == StData) ||
            (state_q == StParityBit) || (state_q == StStop)) begin
          tick_q <= tick_end ? '0 : tick_q + TICK_W'(1);
        end
        unique case (state_q)
          StIdle: begin
            line_q <= 1'b1;
            busy_q <= 1'b0;
          end
          StStart: begin
            if (tick_end) begin
              state_q <= StData;
              line_q  <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
          StData: begin
            if (tick_end) begin
              if (bit_q == BIT_LAST) begin
                state_q <= StParityBit;
                bit_q   <= '0;
                line_q  <= parity_q;
              end else begin
                bit_q   <= bit_q + BIT_W'(1);
                line_q  <= shift_q[0];
                shift_q <= shift_q >> 1;
              end
            end
          end
          StParityBit: begin
            if (tick_end) begin
              state_q <= StStop;
              line_q  <= 1'b1;
            end
          end
          StStop: begin
            if (tick_end) begin
              state_q <= StDone;
              line_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign saida_serial = line_q;
  assign ocupado      = busy_q;
  assign pronto       = done_q;

endmodule

// File: tb/tb_tx_serial.sv
// Bench for tx_serial: two instances (odd and even parity) share the stimulus.
// Frame expectations are hand-written 11-bit vectors, bit i = line level during
// bit period i: {stop, parity, data[7:0], start}.
module tb_tx_serial;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       partida = 1'b0;
  logic [7:0] dados = 8'h00;

  logic line_o, busy_o, done_o;
  logic line_e, busy_e, done_e;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  tx_serial #(
    .BAUD_RATE(10_000),
    .CLOCK_HZ (160_000),
    .N_BITS   (8),
    .PARITY   (1)
  ) dut_odd (
    .clock       (clock),
    .reset       (reset),
    .partida     (partida),
    .dados       (dados),
    .saida_serial(line_o),
    .ocupado     (busy_o),
    .pronto      (done_o)
  );

  tx_serial #(
    .BAUD_RATE(10_000),
    .CLOCK_HZ (160_000),
    .N_BITS   (8),
    .PARITY   (0)
  ) dut_even (
    .clock       (clock),
    .reset       (reset),
    .partida     (partida),
    .dados       (dados),
    .saida_serial(line_e),
    .ocupado     (busy_e),
    .pronto      (done_e)
  );

  typedef struct {
    logic [7:0]  data;
    logic [10:0] exp_odd;
    logic [10:0] exp_even;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " line_odd"},    line_o, 1'b1);
    chk({tag, " line_even"},   line_e, 1'b1);
    chk({tag, " ocupado_odd"}, busy_o, 1'b0);
    chk({tag, " ocupado_even"}, busy_e, 1'b0);
    chk({tag, " pronto_odd"},  done_o, 1'b0);
    chk({tag, " pronto_even"}, done_e, 1'b0);
  endtask

  // Called 1 time unit after the accepting edge; returns in the DONE cycle.
  task automatic chk_frame(input string tag, input logic [10:0] eo, input logic [10:0] ee,
                           input bit keep, input bit poke);
    for (int n = 0; n < 176; n++) begin
      if (n == 0 && !keep) partida = 1'b0;
      if (poke && n == 40) begin
        partida = 1'b1;
        dados   = 8'hFF;
      end
      if (poke && n == 41) partida = 1'b0;
      chk($sformatf("%s n=%0d line_odd", tag, n),  line_o, eo[n/16]);
      chk($sformatf("%s n=%0d line_even", tag, n), line_e, ee[n/16]);
      chk($sformatf("%s n=%0d ocupado", tag, n),   busy_o & busy_e, 1'b1);
      chk($sformatf("%s n=%0d pronto", tag, n),    done_o | done_e, 1'b0);
      step();
    end
    chk({tag, " done pronto_odd"},  done_o, 1'b1);
    chk({tag, " done pronto_even"}, done_e, 1'b1);
    chk({tag, " done ocupado"},     busy_o | busy_e, 1'b0);
    chk({tag, " done line"},        line_o & line_e, 1'b1);
  endtask

  initial begin
    vecs[0] = '{8'h55, 11'b11_01010101_0, 11'b10_01010101_0};
    vecs[1] = '{8'h03, 11'b11_00000011_0, 11'b10_00000011_0};
    vecs[2] = '{8'h00, 11'b11_00000000_0, 11'b10_00000000_0};
    vecs[3] = '{8'h80, 11'b10_10000000_0, 11'b11_10000000_0};
    vecs[4] = '{8'h07, 11'b10_00000111_0, 11'b11_00000111_0};
    vecs[5] = '{8'hFF, 11'b11_11111111_0, 11'b10_11111111_0};
    vecs[6] = '{8'hA5, 11'b11_10100101_0, 11'b10_10100101_0};

    // Reset for two cycles, then idle with partida low.
    reset = 1'b0;
    step();
    step();
    chk_idle("reset");
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk_idle("idle");
      step();
    end

    // Single-pulse frames from the table.
    for (int i = 0; i < 6; i++) begin
      dados   = vecs[i].data;
      partida = 1'b1;
      step();
      chk_frame($sformatf("vec%0d", i), vecs[i].exp_odd, vecs[i].exp_even, 1'b0, 1'b0);
      step();
      chk_idle($sformatf("vec%0d after", i));
      repeat (5) step();
    end

    // Re-request and data change mid-frame must not disturb the frame.
    dados   = 8'h55;
    partida = 1'b1;
    step();
    chk_frame("poke", vecs[0].exp_odd, vecs[0].exp_even, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 40; i++) begin
      chk_idle("poke after");
      step();
    end

    // partida held: two frames with one high cycle (DONE) between them.
    dados   = 8'hA5;
    partida = 1'b1;
    step();
    chk_frame("b2b first", vecs[6].exp_odd, vecs[6].exp_even, 1'b1, 1'b0);
    step();
    chk_frame("b2b second", vecs[6].exp_odd, vecs[6].exp_even, 1'b0, 1'b0);
    step();
    chk_idle("b2b after");
    repeat (5) step();

    // Reset during data bit 4 aborts the frame without a pronto pulse.
    dados   = 8'h55;
    partida = 1'b1;
    step();
    for (int n = 0; n < 85; n++) begin
      if (n == 0) partida = 1'b0;
      step();
    end
    chk("abort pre line_odd", line_o, 1'b1);
    chk("abort pre ocupado", busy_o, 1'b1);
    reset = 1'b0;
    step();
    chk_idle("abort");
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      chk_idle("abort after");
      step();
    end

    // Reset wins over a simultaneous start request.
    reset   = 1'b0;
    partida = 1'b1;
    step();
    chk_idle("rst prio");
    reset   = 1'b1;
    partida = 1'b0;
    step();
    chk_idle("rst prio after");

    // A full frame after the abort.
    dados   = 8'h07;
    partida = 1'b1;
    step();
    chk_frame("post abort", vecs[4].exp_odd, vecs[4].exp_even, 1'b0, 1'b0);
    step();
    chk_idle("post abort after");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
